// File: rtl/dgd_eqv_pkg.sv
// Shared types and helpers for the truth-table equivalence sweeper.
// Truth tables are kept in string order: vector index p lives at bit TT_W-1-p.
package dgd_eqv_pkg;

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} eqv_state_t;

   localparam logic [15:0] TT_0XBDF1 = 16'hBDF1;

   function automatic int unsigned tt_bit(input int unsigned p, input int unsigned tt_w = 16);
      return tt_w - 1 - p;
   endfunction

endpackage

// File: rtl/eqv_settle_timer.sv
// Loadable down-counter with a zero flag; paces the settle time of each vector.
module eqv_settle_timer #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/tt_eqv_sweeper.sv
// Walks every input combination of a combinational netlist, collects its truth table
// and compares it against a reference word.
module tt_eqv_sweeper
   import dgd_eqv_pkg::*;
#(
   parameter int unsigned N_IN   = 4,
   parameter int unsigned SETTLE = 1,
   localparam int unsigned TT_W  = 2 ** N_IN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [TT_W-1:0] expected,
   output logic [N_IN-1:0] stim,
   input  logic            dut_out,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [TT_W-1:0] observed,
   output logic [TT_W-1:0] mismatch,
   output logic            fail_valid,
   output logic [N_IN-1:0] first_fail_idx
);

   localparam int unsigned SW = 4;

   eqv_state_t      r_state;
   logic [N_IN-1:0] r_p;
   logic [N_IN-1:0] r_stim;
   logic [TT_W-1:0] r_exp;
   logic [TT_W-1:0] r_obs;
   logic [TT_W-1:0] r_mm;
   logic            r_pass;
   logic            r_fv;
   logic [N_IN-1:0] r_ffi;
   logic            r_busy;
   logic            r_done;

   logic [N_IN-1:0] w_bit;
   logic [TT_W-1:0] w_obs_next;
   logic            w_last;
   logic            w_load;
   logic            w_zero;

   always_comb begin
      w_bit             = N_IN'(tt_bit(32'(r_p), TT_W));
      w_obs_next        = r_obs;
      w_obs_next[w_bit] = dut_out;
      w_last            = (r_p == N_IN'(TT_W - 1));
      w_load            = ((r_state == IDLE) && start) || ((r_state == SAMPLE) && !w_last);
   end

   eqv_settle_timer #(
      .W (SW)
   ) u_settle (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (SW'(SETTLE)),
      .i_dec      (r_state == DRIVE),
      .o_zero     (w_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_p     <= '0;
         r_stim  <= '0;
         r_exp   <= '0;
         r_obs   <= '0;
         r_mm    <= '0;
         r_pass  <= 1'b0;
         r_fv    <= 1'b0;
         r_ffi   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_exp   <= expected;
                  r_obs   <= '0;
                  r_mm    <= '0;
                  r_pass  <= 1'b0;
                  r_fv    <= 1'b0;
                  r_ffi   <= '0;
                  r_p     <= '0;
                  r_stim  <= '0;
                  r_busy  <= 1'b1;
                  r_state <= DRIVE;
               end
            end
            DRIVE: begin
               if (w_zero) begin
                  r_state <= SAMPLE;
               end
            end
            SAMPLE: begin
               r_obs <= w_obs_next;
               if ((dut_out != r_exp[w_bit]) && !r_fv) begin
                  r_fv  <= 1'b1;
                  r_ffi <= r_p;
               end
               // Results must already be valid while done is high.
               if (w_last) begin
                  r_mm    <= w_obs_next ^ r_exp;
                  r_pass  <= (w_obs_next == r_exp);
                  r_stim  <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_p     <= r_p + N_IN'(1);
                  r_stim  <= r_p + N_IN'(1);
                  r_state <= DRIVE;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign stim           = r_stim;
   assign busy           = r_busy;
   assign done           = r_done;
   assign pass           = r_pass;
   assign observed       = r_obs;
   assign mismatch       = r_mm;
   assign fail_valid     = r_fv;
   assign first_fail_idx = r_ffi;

endmodule

// File: tb/tb_tt_eqv_sweeper.sv
// Self-checking bench: three sweepers (SETTLE = 1, 3, 0) each driving a modelled gate netlist.
module tb_tt_eqv_sweeper;

   localparam int LIMIT = 200;

   typedef struct {
      logic [15:0] gate;
      logic [15:0] exp;
      logic [15:0] obs;
      logic [15:0] mm;
      logic        ps;
      logic        fv;
      logic [3:0]  ffi;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_v [3];
   logic [15:0] exp_v   [3];
   logic [15:0] gate_v  [3];
   logic [3:0]  stim_v  [3];
   logic        busy_v  [3];
   logic        done_v  [3];
   logic        pass_v  [3];
   logic [15:0] obs_v   [3];
   logic [15:0] mm_v    [3];
   logic        fv_v    [3];
   logic [3:0]  ffi_v   [3];
   logic        dut0, dut1, dut2;
   logic [3:0]  d1, d2, d3;

   int n_vec = 0;
   int n_bad = 0;
   int done_cnt0 = 0;

   always #5 clk = ~clk;

   // Gate models: truth table in string order, bit 15-p is the response to input p.
   assign dut0 = gate_v[0][4'd15 - stim_v[0]];
   assign dut2 = gate_v[2][4'd15 - stim_v[2]];
   // Slow netlist: output follows stim three cycles late.
   always @(posedge clk) begin
      d1 <= stim_v[1];
      d2 <= d1;
      d3 <= d2;
   end
   assign dut1 = gate_v[1][4'd15 - d3];

   always @(negedge clk) if (done_v[0]) done_cnt0++;

   tt_eqv_sweeper #(.N_IN(4), .SETTLE(1)) u_dut0 (
      .clk (clk), .rst (rst), .start (start_v[0]), .expected (exp_v[0]), .stim (stim_v[0]),
      .dut_out (dut0), .busy (busy_v[0]), .done (done_v[0]), .pass (pass_v[0]),
      .observed (obs_v[0]), .mismatch (mm_v[0]), .fail_valid (fv_v[0]),
      .first_fail_idx (ffi_v[0])
   );
   tt_eqv_sweeper #(.N_IN(4), .SETTLE(3)) u_dut1 (
      .clk (clk), .rst (rst), .start (start_v[1]), .expected (exp_v[1]), .stim (stim_v[1]),
      .dut_out (dut1), .busy (busy_v[1]), .done (done_v[1]), .pass (pass_v[1]),
      .observed (obs_v[1]), .mismatch (mm_v[1]), .fail_valid (fv_v[1]),
      .first_fail_idx (ffi_v[1])
   );
   tt_eqv_sweeper #(.N_IN(4), .SETTLE(0)) u_dut2 (
      .clk (clk), .rst (rst), .start (start_v[2]), .expected (exp_v[2]), .stim (stim_v[2]),
      .dut_out (dut2), .busy (busy_v[2]), .done (done_v[2]), .pass (pass_v[2]),
      .observed (obs_v[2]), .mismatch (mm_v[2]), .fail_valid (fv_v[2]),
      .first_fail_idx (ffi_v[2])
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, got, want);
      end
   endtask

   // Reference: walk p in order, record the response, note the first disagreement.
   function automatic void ref_model(input logic [15:0] gate, input logic [15:0] exp,
                                     output logic [15:0] obs, output logic [15:0] mm,
                                     output logic ps, output logic fv, output logic [3:0] ffi);
      obs = '0;
      fv  = 1'b0;
      ffi = '0;
      for (int p = 0; p < 16; p++) begin
         logic r;
         r           = gate[15 - p];
         obs[15 - p] = r;
         if (r != exp[15 - p] && !fv) begin
            fv  = 1'b1;
            ffi = 4'(p);
         end
      end
      mm = obs ^ exp;
      ps = (mm == 16'h0000);
   endfunction

   // Returns with ncyc = edges since (and including) the accepting edge, sampled #1 after it.
   task automatic wait_done(input int k, input bit extra_starts, output int ncyc);
      ncyc = 1;
      check("busy_after_start", 32'(busy_v[k]), 32'd1);
      while (!done_v[k] && ncyc < LIMIT) begin
         start_v[k] = extra_starts && (ncyc == 5 || ncyc == 20);
         @(posedge clk); #1;
         ncyc++;
      end
      start_v[k] = 1'b0;
      if (!done_v[k]) begin
         n_vec++;
         n_bad++;
         $display("FAIL done_timeout: inst %0d got no done, want done within %0d cycles", k, LIMIT);
      end else begin
         check("busy_low_at_done", 32'(busy_v[k]), 32'd0);
      end
   endtask

   task automatic sweep(input int k, input logic [15:0] gate, input logic [15:0] exp,
                        input bit extra_starts, output int ncyc);
      gate_v[k] = gate;
      @(posedge clk);
      @(negedge clk);
      start_v[k] = 1'b1;
      exp_v[k]   = exp;
      @(posedge clk); #1;
      start_v[k] = 1'b0;
      exp_v[k]   = ~exp;
      wait_done(k, extra_starts, ncyc);
   endtask

   task automatic check_results(input int k, input logic [15:0] obs, input logic [15:0] mm,
                                input logic ps, input logic fv, input logic [3:0] ffi);
      check("observed", 32'(obs_v[k]), 32'(obs));
      check("mismatch", 32'(mm_v[k]), 32'(mm));
      check("pass", 32'(pass_v[k]), 32'(ps));
      check("fail_valid", 32'(fv_v[k]), 32'(fv));
      check("first_fail_idx", 32'(ffi_v[k]), 32'(ffi));
   endtask

   initial begin
      vec_t        tbl [4];
      int          ncyc;
      int          cnt_before;
      logic [15:0] r_obs, r_mm, g, e;
      logic        r_ps, r_fv;
      logic [3:0]  r_ffi;

      tbl[0] = '{16'hBDF1, 16'hBDF1, 16'hBDF1, 16'h0000, 1'b1, 1'b0, 4'd0};
      tbl[1] = '{16'h0000, 16'hBDF1, 16'h0000, 16'hBDF1, 1'b0, 1'b1, 4'd0};
      tbl[2] = '{16'hBFF1, 16'hBDF1, 16'hBFF1, 16'h0200, 1'b0, 1'b1, 4'd6};
      tbl[3] = '{16'hFFFF, 16'hBDF1, 16'hFFFF, 16'h420E, 1'b0, 1'b1, 4'd1};

      for (int k = 0; k < 3; k++) begin
         start_v[k] = 1'b0;
         exp_v[k]   = '0;
         gate_v[k]  = dgd_eqv_pkg::TT_0XBDF1;
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_done", 32'(done_v[0]), 32'd0);
      check("rst_busy", 32'(busy_v[0]), 32'd0);
      check("rst_stim", 32'(stim_v[0]), 32'd0);
      check_results(0, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0);

      for (int i = 0; i < 4; i++) begin
         sweep(0, tbl[i].gate, tbl[i].exp, 1'b0, ncyc);
         check("done_cycle_s1", 32'(ncyc), 32'd49);
         check_results(0, tbl[i].obs, tbl[i].mm, tbl[i].ps, tbl[i].fv, tbl[i].ffi);
      end

      // Extra starts mid-sweep are ignored; the cycle right after done accepts a new one.
      cnt_before = done_cnt0;
      sweep(0, 16'hBDF1, 16'hBDF1, 1'b1, ncyc);
      check("done_cycle_ignored_starts", 32'(ncyc), 32'd49);
      @(posedge clk); #1;
      check("idle_after_done", 32'(done_v[0]), 32'd0);
      start_v[0] = 1'b1;
      exp_v[0]   = 16'h0000;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      wait_done(0, 1'b0, ncyc);
      check("done_cycle_back_to_back", 32'(ncyc), 32'd49);
      check_results(0, 16'hBDF1, 16'hBDF1, 1'b0, 1'b1, 4'd0);
      @(negedge clk);
      check("done_pulse_count", 32'(done_cnt0 - cnt_before), 32'd2);

      // Reset while p = 7.
      @(posedge clk);
      @(negedge clk);
      start_v[0] = 1'b1;
      exp_v[0]   = 16'hBDF1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      ncyc = 1;
      while (ncyc < 22) begin
         @(posedge clk); #1;
         ncyc++;
      end
      check("stim_at_p7", 32'(stim_v[0]), 32'd7);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_mid_busy", 32'(busy_v[0]), 32'd0);
      check("rst_mid_stim", 32'(stim_v[0]), 32'd0);
      check("rst_mid_observed", 32'(obs_v[0]), 32'd0);
      cnt_before = done_cnt0;
      repeat (80) @(posedge clk);
      #1;
      check("no_done_after_rst", 32'(done_cnt0 - cnt_before), 32'd0);

      sweep(1, 16'hBDF1, 16'hBDF1, 1'b0, ncyc);
      check("done_cycle_s3", 32'(ncyc), 32'd81);
      check_results(1, 16'hBDF1, 16'h0000, 1'b1, 1'b0, 4'd0);

      sweep(2, 16'hBDF1, 16'hBDF1, 1'b0, ncyc);
      check("done_cycle_s0", 32'(ncyc), 32'd33);
      check_results(2, 16'hBDF1, 16'h0000, 1'b1, 1'b0, 4'd0);

      for (int i = 0; i < 12; i++) begin
         int k;
         k = (i % 3 == 2) ? 1 : ((i % 2 == 0) ? 0 : 2);
         g = 16'($urandom);
         case ($urandom_range(0, 2))
            0:       e = g;
            1:       e = g ^ (16'h0001 << $urandom_range(0, 15));
            default: e = 16'($urandom);
         endcase
         ref_model(g, e, r_obs, r_mm, r_ps, r_fv, r_ffi);
         sweep(k, g, e, 1'b0, ncyc);
         check("rand_done_cycle", 32'(ncyc), (k == 0) ? 32'd49 : ((k == 1) ? 32'd81 : 32'd33));
         check_results(k, r_obs, r_mm, r_ps, r_fv, r_ffi);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
